// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, serial-in, parallel-in/serial-out and
// parallel load, with word-complete and transfer busy/done flags.
module univ_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       ser_in,
    output logic [WIDTH-1:0]           dout,
    output logic                       ser_out,
    output logic                       word_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_SER  = 2'b01;
    localparam logic [1:0] M_PISO = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic [WIDTH-1:0] dout_r, dout_n;
    logic [CW-1:0]    cnt_r, cnt_n, cnt_eff;
    logic [1:0]       last_r, last_n;
    logic             busy_r, busy_n;
    logic             wv_r, wv_n;
    logic             done_r, done_n;

    // Shift one position toward the serial output end, inserting b
    function automatic logic [WIDTH-1:0] shift1(
        input logic [WIDTH-1:0] d,
        input logic             b
    );
        if (MSB_FIRST) return {d[WIDTH-2:0], b};
        else           return {b, d[WIDTH-1:1]};
    endfunction

    // Next-state logic; an active transfer overrides the mode input
    always_comb begin
        dout_n  = dout_r;
        cnt_n   = cnt_r;
        last_n  = last_r;
        busy_n  = busy_r;
        wv_n    = 1'b0;
        done_n  = 1'b0;
        cnt_eff = (mode != last_r) ? '0 : cnt_r;
        if (en) begin
            if (busy_r) begin
                if (cnt_r == CNT_LAST) begin
                    busy_n = 1'b0;
                    done_n = 1'b1;
                    cnt_n  = '0;
                end else begin
                    dout_n = shift1(dout_r, 1'b0);
                    cnt_n  = cnt_r + CNT_ONE;
                end
            end else begin
                last_n = mode;
                unique case (mode)
                    M_HOLD: begin
                        cnt_n = cnt_eff;
                    end
                    M_SER: begin
                        dout_n = shift1(dout_r, ser_in);
                        if (cnt_eff == CNT_LAST) begin
                            cnt_n = '0;
                            wv_n  = 1'b1;
                        end else begin
                            cnt_n = cnt_eff + CNT_ONE;
                        end
                    end
                    M_PISO: begin
                        dout_n = data_in;
                        busy_n = 1'b1;
                        cnt_n  = '0;
                    end
                    M_LOAD: begin
                        dout_n = data_in;
                        cnt_n  = '0;
                        wv_n   = 1'b1;
                    end
                    default: begin
                        cnt_n = cnt_eff;
                    end
                endcase
            end
        end
    end

    // State register with synchronous reset that aborts any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= '0;
            cnt_r  <= '0;
            last_r <= M_HOLD;
            busy_r <= 1'b0;
            wv_r   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            dout_r <= dout_n;
            cnt_r  <= cnt_n;
            last_r <= last_n;
            busy_r <= busy_n;
            wv_r   <= wv_n;
            done_r <= done_n;
        end
    end

    assign dout       = dout_r;
    assign ser_out    = MSB_FIRST ? dout_r[WIDTH-1] : dout_r[0];
    assign word_valid = wv_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign bit_cnt    = cnt_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: MSB-first and LSB-first instances share
// stimulus; each vector selects which instance it checks.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, en, ser_in;
    logic [1:0] mode;
    logic [7:0] data_in;

    logic [7:0] m_dout, l_dout;
    logic       m_so, m_wv, m_busy, m_done;
    logic       l_so, l_wv, l_busy, l_done;
    logic [2:0] m_cnt, l_cnt;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .data_in(data_in), .ser_in(ser_in),
        .dout(m_dout), .ser_out(m_so), .word_valid(m_wv),
        .busy(m_busy), .done(m_done), .bit_cnt(m_cnt)
    );

    univ_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .data_in(data_in), .ser_in(ser_in),
        .dout(l_dout), .ser_out(l_so), .word_valid(l_wv),
        .busy(l_busy), .done(l_done), .bit_cnt(l_cnt)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] din;
        logic       sin;
        logic       sel;
        logic [7:0] dout;
        logic       so;
        logic       wv;
        logic       busy;
        logic       done;
        logic [2:0] cnt;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t v(
        input logic r, input logic e, input logic [1:0] m,
        input logic [7:0] di, input logic si, input logic sl,
        input logic [7:0] dq, input logic so, input logic wv,
        input logic bz, input logic dn, input logic [2:0] c,
        input string nm
    );
        vec_t t;
        t.rst = r; t.en = e; t.mode = m; t.din = di; t.sin = si;
        t.sel = sl; t.dout = dq; t.so = so; t.wv = wv;
        t.busy = bz; t.done = dn; t.cnt = c; t.name = nm;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        // rst en mode din sin sel | dout so wv busy done cnt
        // 1: reset then parallel load
        vecs.push_back(v(1,0,2'b00,8'h00,0,0, 8'h00,0,0,0,0,0,"t1_rst_m"));
        vecs.push_back(v(1,0,2'b00,8'h00,0,1, 8'h00,0,0,0,0,0,"t1_rst_l"));
        vecs.push_back(v(0,1,2'b11,8'hA5,0,0, 8'hA5,1,1,0,0,0,"t1_load"));
        vecs.push_back(v(0,1,2'b00,8'h00,0,0, 8'hA5,1,0,0,0,0,"t1_hold"));
        // 2: serial-in 1,0,1,1,0,0,1,0
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h4B,0,0,0,0,1,"t2_s1"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h96,1,0,0,0,2,"t2_s2"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h2D,0,0,0,0,3,"t2_s3"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h5B,0,0,0,0,4,"t2_s4"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hB6,1,0,0,0,5,"t2_s5"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h6C,0,0,0,0,6,"t2_s6"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'hD9,1,0,0,0,7,"t2_s7"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hB2,1,1,0,0,0,"t2_s8"));
        // 2b: same bits with en toggling
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h65,0,0,0,0,1,"t2b_s1"));
        vecs.push_back(v(0,0,2'b01,8'h00,0,0, 8'h65,0,0,0,0,1,"t2b_g1"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hCA,1,0,0,0,2,"t2b_s2"));
        vecs.push_back(v(0,0,2'b01,8'h00,1,0, 8'hCA,1,0,0,0,2,"t2b_g2"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h95,1,0,0,0,3,"t2b_s3"));
        vecs.push_back(v(0,0,2'b01,8'h00,0,0, 8'h95,1,0,0,0,3,"t2b_g3"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h2B,0,0,0,0,4,"t2b_s4"));
        vecs.push_back(v(0,0,2'b01,8'h00,0,0, 8'h2B,0,0,0,0,4,"t2b_g4"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h56,0,0,0,0,5,"t2b_s5"));
        vecs.push_back(v(0,0,2'b01,8'h00,1,0, 8'h56,0,0,0,0,5,"t2b_g5"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hAC,1,0,0,0,6,"t2b_s6"));
        vecs.push_back(v(0,0,2'b01,8'h00,1,0, 8'hAC,1,0,0,0,6,"t2b_g6"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h59,0,0,0,0,7,"t2b_s7"));
        vecs.push_back(v(0,0,2'b01,8'h00,0,0, 8'h59,0,0,0,0,7,"t2b_g7"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hB2,1,1,0,0,0,"t2b_s8"));
        // 3: PISO C3 MSB-first, mode=11 mid-transfer ignored
        vecs.push_back(v(0,1,2'b10,8'hC3,0,0, 8'hC3,1,0,1,0,0,"t3_load"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h86,1,0,1,0,1,"t3_b1"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h0C,0,0,1,0,2,"t3_b2"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h18,0,0,1,0,3,"t3_b3"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h30,0,0,1,0,4,"t3_b4"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h60,0,0,1,0,5,"t3_b5"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'hC0,1,0,1,0,6,"t3_b6"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h80,1,0,1,0,7,"t3_b7"));
        vecs.push_back(v(0,1,2'b11,8'hFF,0,0, 8'h80,1,0,0,1,0,"t3_done"));
        vecs.push_back(v(0,1,2'b00,8'h00,0,0, 8'h80,1,0,0,0,0,"t3_after"));
        // 5: reset mid-PISO, en=0 stall, then full transfer + back-to-back
        vecs.push_back(v(0,1,2'b10,8'hC3,0,0, 8'hC3,1,0,1,0,0,"t5_load"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h86,1,0,1,0,1,"t5_b1"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h0C,0,0,1,0,2,"t5_b2"));
        vecs.push_back(v(0,0,2'b10,8'h00,0,0, 8'h0C,0,0,1,0,2,"t5_stall"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h18,0,0,1,0,3,"t5_b3"));
        vecs.push_back(v(1,1,2'b10,8'hFF,0,0, 8'h00,0,0,0,0,0,"t5_rst"));
        vecs.push_back(v(0,1,2'b10,8'h81,0,0, 8'h81,1,0,1,0,0,"t5_load2"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h02,0,0,1,0,1,"t5_c1"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h04,0,0,1,0,2,"t5_c2"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h08,0,0,1,0,3,"t5_c3"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h10,0,0,1,0,4,"t5_c4"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h20,0,0,1,0,5,"t5_c5"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h40,0,0,1,0,6,"t5_c6"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h80,1,0,1,0,7,"t5_c7"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,0, 8'h80,1,0,0,1,0,"t5_done"));
        vecs.push_back(v(0,1,2'b10,8'h3C,0,0, 8'h3C,0,0,1,0,0,"t5_b2b"));
        // 6: serial 3 bits, hold 2, serial 8 more
        vecs.push_back(v(1,0,2'b00,8'h00,0,0, 8'h00,0,0,0,0,0,"t6_rst"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h01,0,0,0,0,1,"t6_s1"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h03,0,0,0,0,2,"t6_s2"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,0, 8'h07,0,0,0,0,3,"t6_s3"));
        vecs.push_back(v(0,1,2'b00,8'h00,1,0, 8'h07,0,0,0,0,0,"t6_h1"));
        vecs.push_back(v(0,1,2'b00,8'h00,1,0, 8'h07,0,0,0,0,0,"t6_h2"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h0E,0,0,0,0,1,"t6_r1"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h1C,0,0,0,0,2,"t6_r2"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h38,0,0,0,0,3,"t6_r3"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h70,0,0,0,0,4,"t6_r4"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hE0,1,0,0,0,5,"t6_r5"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'hC0,1,0,0,0,6,"t6_r6"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h80,1,0,0,0,7,"t6_r7"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,0, 8'h00,0,1,0,0,0,"t6_r8"));
        // 4: LSB-first PISO of C3 then back-to-back 01
        vecs.push_back(v(1,0,2'b00,8'h00,0,1, 8'h00,0,0,0,0,0,"t4_rst"));
        vecs.push_back(v(0,1,2'b10,8'hC3,0,1, 8'hC3,1,0,1,0,0,"t4_load"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h61,1,0,1,0,1,"t4_b1"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h30,0,0,1,0,2,"t4_b2"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h18,0,0,1,0,3,"t4_b3"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h0C,0,0,1,0,4,"t4_b4"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h06,0,0,1,0,5,"t4_b5"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h03,1,0,1,0,6,"t4_b6"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h01,1,0,1,0,7,"t4_b7"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h01,1,0,0,1,0,"t4_done"));
        vecs.push_back(v(0,1,2'b10,8'h01,0,1, 8'h01,1,0,1,0,0,"t4_l01"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,1,"t4_z1"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,2,"t4_z2"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,3,"t4_z3"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,4,"t4_z4"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,5,"t4_z5"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,6,"t4_z6"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,1,0,7,"t4_z7"));
        vecs.push_back(v(0,1,2'b10,8'h00,0,1, 8'h00,0,0,0,1,0,"t4_done2"));
        // LSB-first serial-in enters at the MSB end
        vecs.push_back(v(1,0,2'b00,8'h00,0,1, 8'h00,0,0,0,0,0,"t4_rst2"));
        vecs.push_back(v(0,1,2'b01,8'h00,1,1, 8'h80,0,0,0,0,1,"t4_si1"));
        vecs.push_back(v(0,1,2'b01,8'h00,0,1, 8'h40,0,0,0,0,2,"t4_si2"));

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            en      = vecs[i].en;
            mode    = vecs[i].mode;
            data_in = vecs[i].din;
            ser_in  = vecs[i].sin;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (e.sel) begin
                chk({e.name, ".dout"}, int'(l_dout), int'(e.dout));
                chk({e.name, ".ser_out"}, int'(l_so), int'(e.so));
                chk({e.name, ".word_valid"}, int'(l_wv), int'(e.wv));
                chk({e.name, ".busy"}, int'(l_busy), int'(e.busy));
                chk({e.name, ".done"}, int'(l_done), int'(e.done));
                chk({e.name, ".bit_cnt"}, int'(l_cnt), int'(e.cnt));
            end else begin
                chk({e.name, ".dout"}, int'(m_dout), int'(e.dout));
                chk({e.name, ".ser_out"}, int'(m_so), int'(e.so));
                chk({e.name, ".word_valid"}, int'(m_wv), int'(e.wv));
                chk({e.name, ".busy"}, int'(m_busy), int'(e.busy));
                chk({e.name, ".done"}, int'(m_done), int'(e.done));
                chk({e.name, ".bit_cnt"}, int'(m_cnt), int'(e.cnt));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register. Generalises the team's fixed 4-bit parallel-in/parallel-out register to WIDTH bits.
- Supports four operating modes selected per cycle:
  - hold;
  - serial-in (SISO/SIPO, with word-complete flag);
  - parallel-in/serial-out (PISO, with busy/done handshake);
  - parallel load (PIPO).
- Sits between parallel datapaths and serial links (UART/SPI-style framers) in the design.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = shift toward MSB (serial I/O at MSB end); 0 = shift toward LSB (serial I/O at LSB end).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  clock enable; no state change when 0
- mode  input  2  00 hold, 01 serial-in, 10 PISO, 11 parallel load
- data_in  input  WIDTH  parallel input word
- ser_in  input  1  serial input bit
- dout  output  WIDTH  shift register contents (registered)
- ser_out  output  1  serial output bit
- word_valid  output  1  one-cycle pulse: a full word is in dout
- busy  output  1  PISO transfer in progress
- done  output  1  one-cycle pulse: PISO transfer finished
- bit_cnt  output  $clog2(WIDTH)  bits shifted in the current word

Behaviour:
- Reset: clk and rst are the only clock/reset. rst is synchronous and active-high, and takes priority over everything else. On reset:
  - dout=0, busy=0, word_valid=0, done=0, bit_cnt=0;
  - internal last_mode=00;
  - any in-flight transfer is aborted with no done pulse.
- Serial output: ser_out = dout[WIDTH-1] if MSB_FIRST, else dout[0]. It is combinational from the register, so its reset value is 0.
- Pulse outputs: word_valid and done are registered and default to 0 every cycle. They are high only for the cycle following the qualifying edge.
- en=0: all registers hold and the pulses drop to 0.
- Mode-change rule: an en cycle whose mode differs from last_mode clears bit_cnt to 0 before acting. last_mode updates on every en cycle except while busy=1.
- Busy override: while busy=1, the mode input is ignored and the PISO transfer runs to completion.
- mode 00 (hold): no change to any register.
- mode 11 (parallel load): dout <= data_in (1-cycle latency). word_valid pulses the next cycle; bit_cnt <= 0.
- mode 01 (serial-in):
  - Each en cycle shifts:
    - MSB_FIRST=1: dout <= {dout[WIDTH-2:0], ser_in};
    - MSB_FIRST=0: dout <= {ser_in, dout[WIDTH-1:1]}.
  - bit_cnt increments each shift. On the shift where bit_cnt==WIDTH-1, bit_cnt wraps to 0 and word_valid pulses.
  - Shifting is continuous: the next word starts immediately with no gap.
  - ser_out is ser_in delayed by WIDTH en cycles (SISO behaviour).
- mode 10 (PISO):
  - Start (busy=0, en=1): dout <= data_in, busy <= 1, bit_cnt <= 0. The first bit appears on ser_out the cycle after the load.
  - While busy, each en cycle:
    - if bit_cnt==WIDTH-1: busy <= 0, done pulses, bit_cnt <= 0, dout holds;
    - else: shift one position with 0 fill, bit_cnt++.
  - Each bit is therefore presented for exactly one en cycle; the transfer takes WIDTH+1 en cycles including the load.
  - Back-to-back: if mode=10 and en=1 in the cycle after done, a new load starts.
- Simultaneous events: rst beats en, and busy beats mode.
- Registers use nonblocking assignment only.

Test Plan:
1. WIDTH=8, MSB_FIRST=1. Reset, then mode=11, data_in=8'hA5, en=1 for one cycle -> dout=8'hA5 and word_valid=1 the following cycle; word_valid=0 after that; bit_cnt=0.
2. mode=01, ser_in bits 1,0,1,1,0,0,1,0 over 8 en cycles -> dout=8'hB2, word_valid pulses exactly once after the 8th shift, bit_cnt wraps 7->0. Repeat with en toggling 1,0,1,0 -> same result, with no change on en=0 cycles.
3. mode=10, data_in=8'hC3 -> busy=1 for 8 en cycles; ser_out sequence 1,1,0,0,0,0,1,1; done=1 once and busy=0 after the 9th en cycle. Changing mode to 11 mid-transfer has no effect.
4. MSB_FIRST=0, PISO of 8'hC3 -> ser_out sequence 1,1,0,0,0,0,1,1 taken LSB-first (C3 is palindromic in bits; also run 8'h01 -> 1 then seven 0s).
5. Reset mid-PISO after 3 bits -> next cycle dout=0, busy=0, bit_cnt=0, no done pulse. A new PISO load then completes normally.
6. Serial-in 3 bits, switch to mode 00 for 2 cycles, back to 01 -> bit_cnt restarts at 0, and word_valid fires only after 8 further shifts.
